// File: rtl/apb_master_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_master_bridge : valid/ready command stream to APB master bridge.     |
// | Optional APB_TIMEOUT_EN aborts long PREADY-low waits with rsp_err.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET_N,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t r_state;

  // Decoded from the registered state, so it reads 1 while reset is held.
  assign cmd_ready = (r_state == IDLE);

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err;
  logic             w_timeout;

  // The abort fires in the wait cycle that would bring the count to the limit.
  assign w_timeout = (r_wait_cnt == C_LAST_WAIT) && !PREADY;
  assign rsp_err   = r_err;
`else
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      r_state    <= IDLE;
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
`ifdef APB_TIMEOUT_EN
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            PADDR   <= cmd_addr;
            PWRITE  <= cmd_write;
            PWDATA  <= cmd_wdata;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            r_state <= SETUP;
          end
        end

        SETUP: begin
          PENABLE    <= 1'b1;
          r_state    <= ACCESS;
`ifdef APB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end

        ACCESS: begin
          if (PREADY) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            r_state   <= RESP;
`ifdef APB_TIMEOUT_EN
            r_err     <= 1'b0;
          end else if (w_timeout) begin
            rsp_rdata <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
`endif
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_apb_master_bridge : directed self-checking bench for apb_master_bridge|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_apb_master_bridge;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          PCLK = 1'b0;
  logic          PRESET_N;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  int n_cmp = 0;
  int n_mis = 0;
  int en_cnt;
  logic done;
  logic prev_psel = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK),
    .PRESET_N(PRESET_N),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PADDR(PADDR),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  // APB protocol rules watched every cycle on the falling edge.
  always @(negedge PCLK) begin
    check("penable_needs_psel", {31'b0, PENABLE & ~PSEL}, 32'd0);
    if (PSEL && !prev_psel)
      check("penable_on_psel_rise", {31'b0, PENABLE}, 32'd0);
    prev_psel <= PSEL;
  end

  initial begin
    PRESET_N  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;

    #12;
    check("rst_psel",      PSEL,      0);
    check("rst_penable",   PENABLE,   0);
    check("rst_pwrite",    PWRITE,    0);
    check("rst_paddr",     PADDR,     0);
    check("rst_pwdata",    PWDATA,    0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err",   rsp_err,   0);
    check("rst_cmd_ready", cmd_ready, 1);
    tick;
    PRESET_N = 1'b1;
    tick;

    // Write, zero wait states
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'hA5; PREADY = 1'b1;
    tick;
    cmd_valid = 1'b0;
    check("t1_setup_psel",    PSEL,      1);
    check("t1_setup_penable", PENABLE,   0);
    check("t1_paddr",         PADDR,     8'h10);
    check("t1_pwdata",        PWDATA,    8'hA5);
    check("t1_pwrite",        PWRITE,    1);
    check("t1_cmd_ready",     cmd_ready, 0);
    tick;
    check("t1_access_psel",    PSEL,      1);
    check("t1_access_penable", PENABLE,   1);
    check("t1_access_pwdata",  PWDATA,    8'hA5);
    check("t1_no_early_rsp",   rsp_valid, 0);
    tick;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_rdata", rsp_rdata, 8'h00);
    check("t1_rsp_err",   rsp_err,   0);
    check("t1_psel_drop", PSEL,      0);
    check("t1_pen_drop",  PENABLE,   0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("t1_rsp_clear", rsp_valid, 0);
    check("t1_idle",      cmd_ready, 1);

    // Read with 3 wait states
    PREADY = 1'b0; PRDATA = 8'hEE;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h3C; cmd_wdata = 8'h11;
    tick;
    cmd_valid = 1'b0;
    check("t2_setup_psel", PSEL,   1);
    check("t2_pwrite",     PWRITE, 0);
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (PENABLE) en_cnt++;
      check("t2_paddr_stable", PADDR,     8'h3C);
      check("t2_rsp_wait",     rsp_valid, 0);
      if (i == 3) begin
        PREADY = 1'b1; PRDATA = 8'h5E;
      end
    end
    tick;
    check("t2_penable_cycles", en_cnt,    4);
    check("t2_rsp_valid",      rsp_valid, 1);
    check("t2_rsp_rdata",      rsp_rdata, 8'h5E);
    check("t2_rsp_err",        rsp_err,   0);
    PRDATA = 8'hC3; rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("t2_rsp_clear", rsp_valid, 0);

    // Response backpressure with a second command waiting
    PREADY = 1'b1; PRDATA = 8'h77;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20;
    tick;
    cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'h66;
    tick;
    tick;
    PRDATA = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", rsp_valid, 1);
      check("t3_hold_rdata", rsp_rdata, 8'h77);
      check("t3_cmd_blocked", cmd_ready, 0);
      check("t3_no_psel",     PSEL,      0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("t3_handshake",    rsp_valid, 0);
    check("t3_ready_after",  cmd_ready, 1);
    check("t3_not_accepted", PSEL,      0);
    tick;
    cmd_valid = 1'b0;
    check("t3_second_psel",  PSEL,   1);
    check("t3_second_paddr", PADDR,  8'h55);
    check("t3_second_pwdat", PWDATA, 8'h66);
    tick;
    tick;
    check("t3_second_rsp",   rsp_valid, 1);
    check("t3_second_rdata", rsp_rdata, 8'h00);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    // Back-to-back writes, one transfer every 4 cycles
    cmd_valid = 1'b1; cmd_write = 1'b1; PREADY = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cmd_addr  = 8'(k);
      cmd_wdata = 8'(8'h20 + k);
      tick;
      check("t4_setup_psel",    PSEL,    1);
      check("t4_setup_penable", PENABLE, 0);
      check("t4_paddr_order",   PADDR,   k);
      check("t4_pwdata",        PWDATA,  8'h20 + k);
      tick;
      check("t4_access_penable", PENABLE, 1);
      tick;
      check("t4_rsp_valid", rsp_valid, 1);
      check("t4_psel_low",  PSEL,      0);
      tick;
      check("t4_rsp_done",  rsp_valid, 0);
      check("t4_idle",      cmd_ready, 1);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;

    // Reset in the middle of ACCESS
    PREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h42;
    tick;
    cmd_valid = 1'b0;
    tick;
    check("t5_in_access", PENABLE, 1);
    #2;
    PRESET_N = 1'b0;
    #1;
    check("t5_async_psel",    PSEL,      0);
    check("t5_async_penable", PENABLE,   0);
    check("t5_paddr_reset",   PADDR,     0);
    PREADY = 1'b1; PRDATA = 8'h99;
    tick;
    tick;
    PRESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("t5_no_stale_rsp", rsp_valid, 0);
      check("t5_cmd_ready",    cmd_ready, 1);
      check("t5_psel_idle",    PSEL,      0);
    end

`ifdef APB_TIMEOUT_EN
    // Timeout abort after 16 PREADY-low ACCESS cycles, then a normal transfer
    PREADY = 1'b0; PRDATA = 8'hAB;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h80;
    tick;
    cmd_valid = 1'b0;
    en_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick;
      if (rsp_valid) done = 1'b1;
      else if (PENABLE) en_cnt++;
    end
    check("t6_abort_seen",   done,      1);
    check("t6_access_count", en_cnt,    16);
    check("t6_rsp_err",      rsp_err,   1);
    check("t6_rsp_rdata",    rsp_rdata, 8'h00);
    check("t6_psel_low",     PSEL,      0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    PREADY = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 8'h81;
    tick;
    cmd_valid = 1'b0;
    tick;
    tick;
    check("t6_next_valid", rsp_valid, 1);
    check("t6_next_err",   rsp_err,   0);
    check("t6_next_rdata", rsp_rdata, 8'hAB);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
`endif

    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
